regfile_wr_sched: RTL and testbench
===================================

REGFILE_WR_SCHED -- requirements
Module: regfile_wr_sched

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 64, width of register data.
REQ-002 SHALL provide parameter NR_REQ, default 3, number of write requesters (legal 2..8).
REQ-003 SHALL provide port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL provide port req_valid_i  input  NR_REQ  per-requester write request valid.
REQ-006 SHALL provide port req_ready_o  output  NR_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 SHALL provide port req_addr_i  input  NR_REQ x 5  per-requester destination register index.
REQ-008 SHALL provide port req_data_i  input  NR_REQ x DATA_WIDTH  per-requester write data.
REQ-009 SHALL provide port clr_req_i  input  1  request to zero registers x1..x31.
REQ-010 SHALL provide port clr_busy_o  output  1  high while clear sequence runs.
REQ-011 SHALL provide port we_o  output  1  register file write enable.
REQ-012 SHALL provide port waddr_o  output  5  register file write address.
REQ-013 SHALL provide port wdata_o  output  DATA_WIDTH  register file write data.

Function
REQ-014 SHALL implement FSM with states IDLE and CLEAR.
REQ-015 In IDLE with clr_req_i=1: no req_ready_o asserted, next state CLEAR, clear counter loaded with 1.
REQ-016 In IDLE with clr_req_i=0: SHALL grant exactly one valid requester by round-robin; handshake = req_valid_i[k] & req_ready_o[k].
REQ-017 req_ready_o SHALL be combinational: high only for the granted index, only in IDLE, only when clr_req_i=0 and that requester is valid.
REQ-018 Round-robin search SHALL start at pointer rr_ptr and wrap from NR_REQ-1 to 0; after a handshake by k, rr_ptr <= (k+1) mod NR_REQ; no handshake leaves rr_ptr unchanged.
REQ-019 Handshake SHALL register waddr_o/wdata_o from the winner and we_o=1 on the next cycle (latency exactly 1); otherwise we_o=0 next cycle.
REQ-020 Handshake with addr 0 SHALL be accepted (ready high) but SHALL produce we_o=0.
REQ-021 In CLEAR: each cycle SHALL output we_o=1, waddr_o=counter, wdata_o=0 (registered, 1-cycle latency), counter increments; all req_ready_o=0.
REQ-022 CLEAR SHALL issue addresses 1..31 exactly once, in ascending order (31 writes); after issuing 31 returns to IDLE.
REQ-023 clr_busy_o SHALL be high every cycle state==CLEAR and low otherwise.
REQ-024 clr_req_i asserted during CLEAR SHALL be ignored (no restart, no extension).
REQ-025 wdata_o and waddr_o SHALL hold last value when we_o=0.
REQ-026 Grant SHALL not depend on req_addr_i or req_data_i.

Reset
REQ-027 rst_i=1 at a rising edge SHALL set state IDLE, rr_ptr=0, counter=0, we_o=0, waddr_o=0, wdata_o=0, clr_busy_o=0; req_ready_o all 0 while rst_i=1.
REQ-028 Reset during CLEAR SHALL abort the sequence immediately; remaining addresses not written.

Verification
REQ-029 Reset, then req_valid_i=3'b001, addr 5, data 0xA5 -> req_ready_o=3'b001 same cycle; next cycle we_o=1, waddr_o=5, wdata_o=0xA5.
REQ-030 All three valid continuously, rr_ptr=0 -> grants 0,1,2,0 over four cycles; we_o=1 each following cycle.
REQ-031 Requester 1 valid with addr 0 -> ready high, next cycle we_o=0, rr_ptr becomes 2.
REQ-032 clr_req_i pulse with requester 0 valid -> no ready that cycle; clr_busy_o high 31 cycles; we_o writes x1..x31 with 0; requester 0 granted first cycle back in IDLE.
REQ-033 rst_i asserted on 10th CLEAR cycle -> next cycle we_o=0, clr_busy_o=0, state IDLE, rr_ptr=0.
REQ-034 clr_req_i held high for 40 cycles -> CLEAR of 31 writes, one IDLE cycle with no grant, then a second CLEAR starts.

Source files
------------

// File: rtl/regfile_wr_sched.sv
// -----------------------------------------------------------------------------
// regfile_wr_sched
//
// Serialises register-file writes from NR_REQ requesters onto a single write
// port and provides a bulk-clear sequence that zeroes x1..x31.
//
// In IDLE, one valid requester is granted each cycle by round-robin. The
// winner's address and data appear on the write port one cycle later. A write
// to x0 is accepted but dropped. A clear request moves the block to CLEAR.
// CLEAR then issues the zero writes to x1..x31 in ascending order, one per
// cycle, and returns to IDLE.
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   req_valid_i  per-requester write request
//   req_ready_o  per-requester accept (one-hot or zero, combinational)
//   req_addr_i   per-requester destination index, requester k at [k*5 +: 5]
//   req_data_i   per-requester write data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   clr_req_i    request to zero x1..x31
//   clr_busy_o   high while the clear sequence runs
//   we_o         register file write enable
//   waddr_o      register file write address (holds when we_o=0)
//   wdata_o      register file write data (holds when we_o=0)
// -----------------------------------------------------------------------------
module regfile_wr_sched #(
  parameter int DATA_WIDTH = 64,
  parameter int NR_REQ     = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NR_REQ-1:0]            req_valid_i,
  output logic [NR_REQ-1:0]            req_ready_o,
  input  logic [NR_REQ*5-1:0]          req_addr_i,
  input  logic [NR_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic                         clr_req_i,
  output logic                         clr_busy_o,
  output logic                         we_o,
  output logic [4:0]                   waddr_o,
  output logic [DATA_WIDTH-1:0]        wdata_o
);

  localparam int PTR_W = $clog2(NR_REQ);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [4:0]              waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  // Arbitration results
  logic [NR_REQ-1:0]       grant_oh;
  logic [PTR_W-1:0]        next_ptr;
  logic [4:0]              win_addr;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    accept;

  // Rotating priority search: the requester at rr_ptr_q has the highest
  // priority, and the search wraps past NR_REQ-1 back to 0. Only address
  // and data are muxed by the result. They never influence it.
  always_comb begin
    int               idx;
    logic             found;
    logic [PTR_W-1:0] idx_w;
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves it unassigned and no latch is inferred.
    idx      = 0;
    idx_w    = '0;
    found    = 1'b0;
    grant_oh = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NR_REQ) idx = idx - NR_REQ;
      idx_w = idx[PTR_W-1:0];
      if (!found && req_valid_i[idx_w]) begin
        found           = 1'b1;
        grant_oh[idx_w] = 1'b1;
      end
    end
  end

  // One-hot grant to winner payload and the pointer value after it.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    next_ptr = rr_ptr_q;
    for (int i = 0; i < NR_REQ; i++) begin
      if (grant_oh[i]) begin
        win_addr = req_addr_i[i*5 +: 5];
        win_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        next_ptr = (i == NR_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // A grant is only offered in IDLE, when no clear is requested and the
  // block is out of reset. Since ready is only raised for a valid
  // requester, a raised ready is always a handshake.
  assign accept      = (state_q == ST_IDLE) && !clr_req_i && !rst_i && (|req_valid_i);
  assign req_ready_o = accept ? grant_oh : '0;

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d = ST_CLEAR;
          cnt_d   = 5'd1;
        end else if (|req_valid_i) begin
          rr_ptr_d = next_ptr;
          // A write to x0 is consumed but never reaches the register file.
          // The port keeps its previous address and data.
          if (win_addr != 5'd0) begin
            we_d    = 1'b1;
            waddr_d = win_addr;
            wdata_d = win_data;
          end
        end
      end
      ST_CLEAR: begin
        // clr_req_i is deliberately ignored here. The sequence always runs
        // exactly 31 writes.
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = '0;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // update together from the values computed in the current cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign clr_busy_o = (state_q == ST_CLEAR);
  assign we_o       = we_q;
  assign waddr_o    = waddr_q;
  assign wdata_o    = wdata_q;

endmodule

// File: tb/tb_regfile_wr_sched.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_sched
//
// Self-checking bench for regfile_wr_sched. It runs directed scenarios first,
// then randomised traffic with occasional clear requests and resets. Every
// cycle, the DUT is compared against a behavioural model. In that model:
//   - the arbiter is a modular search from an integer pointer;
//   - a clear is a queue of pending addresses 1..31;
//   - the write port is the set of values the model expects to see.
// -----------------------------------------------------------------------------
module tb_regfile_wr_sched;

  localparam int DW = 64;
  localparam int NR = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR*5-1:0]    req_addr;
  logic [NR*DW-1:0]   req_data;
  logic               clr_req;
  logic               clr_busy;
  logic               we;
  logic [4:0]         waddr;
  logic [DW-1:0]      wdata;

  always #5 clk = ~clk;

  regfile_wr_sched #(
    .DATA_WIDTH (DW),
    .NR_REQ     (NR)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .clr_req_i   (clr_req),
    .clr_busy_o  (clr_busy),
    .we_o        (we),
    .waddr_o     (waddr),
    .wdata_o     (wdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int             m_ptr;
  int             m_clr_q[$];
  logic           m_we;
  logic [4:0]     m_waddr;
  logic [DW-1:0]  m_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0;
    m_clr_q.delete();
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endfunction

  // Index of the requester the model expects to win this cycle, or -1.
  function automatic int model_pick();
    if (rst || clr_req || m_clr_q.size() != 0) return -1;
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (m_ptr + i) % NR;
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  function automatic void set_req(input int k, input logic [4:0] a, input logic [DW-1:0] d);
    req_addr[k*5 +: 5]   = a;
    req_data[k*DW +: DW] = d;
  endfunction

  // Inputs are already driven (just after a falling edge). This task checks
  // the combinational outputs, advances the model across the rising edge,
  // and checks the registered outputs at the next falling edge.
  task automatic cycle();
    int            g;
    logic [NR-1:0] exp_ready;
    logic [4:0]    ga;
    #1;
    g         = model_pick();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("clr_busy",  64'(clr_busy),  64'(m_clr_q.size() != 0));

    if (rst) begin
      model_reset();
    end else if (m_clr_q.size() != 0) begin
      m_we    = 1'b1;
      m_waddr = 5'(m_clr_q.pop_front());
      m_wdata = '0;
    end else if (clr_req) begin
      for (int a = 1; a < 32; a++) m_clr_q.push_back(a);
      m_we = 1'b0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NR;
      ga    = req_addr[g*5 +: 5];
      if (ga != 5'd0) begin
        m_we    = 1'b1;
        m_waddr = ga;
        m_wdata = req_data[g*DW +: DW];
      end else begin
        m_we = 1'b0;
      end
    end else begin
      m_we = 1'b0;
    end

    @(negedge clk);
    check("we",    64'(we),    64'(m_we));
    check("waddr", 64'(waddr), 64'(m_waddr));
    check("wdata", wdata,      m_wdata);
  endtask

  task automatic idle_inputs();
    rst       = 1'b0;
    clr_req   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    // Let the synchronous reset take effect before the first comparison.
    repeat (2) @(negedge clk);
    check("reset_we",    64'(we),       64'd0);
    check("reset_waddr", 64'(waddr),    64'd0);
    check("reset_wdata", wdata,         64'd0);
    check("reset_busy",  64'(clr_busy), 64'd0);
    check("reset_ready", 64'(req_ready), 64'd0);
    cycle();  // one more reset cycle, now under model control
    rst = 1'b0;

    // Single requester 0, addr 5, data 0xA5
    req_valid = 3'b001;
    set_req(0, 5'd5, 64'hA5);
    cycle();
    req_valid = '0;
    cycle();

    // All three valid from rr_ptr=0: grants 0,1,2,0
    do_reset();
    req_valid = 3'b111;
    set_req(0, 5'd10, 64'h1111);
    set_req(1, 5'd11, 64'h2222);
    set_req(2, 5'd12, 64'h3333);
    repeat (4) cycle();
    req_valid = '0;
    cycle();

    // Write to x0 by requester 1: accepted, dropped, pointer moves to 2
    do_reset();
    req_valid = 3'b010;
    set_req(1, 5'd0, 64'hDEAD);
    cycle();
    req_valid = 3'b111;
    set_req(0, 5'd3, 64'h30);
    set_req(1, 5'd4, 64'h40);
    set_req(2, 5'd7, 64'h70);
    cycle();
    req_valid = '0;
    cycle();

    // Clear pulse with requester 0 waiting
    do_reset();
    req_valid = 3'b001;
    set_req(0, 5'd9, 64'h99);
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    repeat (33) cycle();
    req_valid = '0;
    cycle();

    // Reset on the 10th clear cycle aborts the sequence
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    repeat (9) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (3) cycle();

    // Clear request held for 40 cycles: one IDLE gap, then a second clear
    req_valid = 3'b111;
    clr_req   = 1'b1;
    repeat (40) cycle();
    clr_req = 1'b0;
    repeat (30) cycle();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      clr_req   = ($urandom_range(0, 59) == 0);
      req_valid = NR'($urandom);
      for (int k = 0; k < NR; k++) begin
        logic [4:0] a;
        a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        set_req(k, a, {$urandom, $urandom});
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
